// File: rtl/pipelined_cache_miss_ctrl.sv
// Miss controller for a two-stage pipelined cache.
// When stage 2 misses, this block freezes the pipeline. If the victim line is dirty, it
// writes the victim back to memory. It then reads the missing line into a fill buffer
// and spends one cycle installing that line into the array.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   s2_*                stage-2 request and victim information (held stable while stalled)
//   pmem_resp/rdata     memory handshake completion and read line
//   pmem_read/write     memory requests (mutually exclusive), pmem_address/wdata
//   stall               combinational pipeline hold
//   fill_we/way/data    array fill port, valid in the FILL cycle only
//   miss_done           stage-2 request completes from fill_data this cycle
//   miss_count/wb_count saturating event counters
//   CountMax            counter ceiling (16'hFFFF in normal use)
module pipelined_cache_miss_ctrl #(
   parameter logic [15:0] CountMax = 16'hFFFF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         s2_valid,
   input  logic         s2_hit,
   input  logic         s2_dirty,
   input  logic         s2_lru,
   input  logic [31:0]  s2_address,
   input  logic [23:0]  s2_victim_tag,
   input  logic [255:0] s2_victim_data,
   input  logic         pmem_resp,
   input  logic [255:0] pmem_rdata,
   output logic         pmem_read,
   output logic         pmem_write,
   output logic [31:0]  pmem_address,
   output logic [255:0] pmem_wdata,
   output logic         stall,
   output logic         fill_we,
   output logic         fill_way,
   output logic [255:0] fill_data,
   output logic         miss_done,
   output logic [15:0]  miss_count,
   output logic [15:0]  wb_count
);

   typedef enum logic [1:0] {StIdle, StWriteback, StAllocate, StFill} state_e;

   state_e        state_q;
   logic [255:0]  fill_buf_q;
   logic [15:0]   miss_cnt_q;
   logic [15:0]   wb_cnt_q;
   logic          s2_miss;

   assign s2_miss = s2_valid & ~s2_hit;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         fill_buf_q <= '0;
         miss_cnt_q <= '0;
         wb_cnt_q   <= '0;
      end else begin
         case (state_q)
            StIdle: begin
               if (s2_miss) begin
                  state_q <= s2_dirty ? StWriteback : StAllocate;
                  if (miss_cnt_q != CountMax) miss_cnt_q <= miss_cnt_q + 16'd1;
                  if (s2_dirty && (wb_cnt_q != CountMax)) wb_cnt_q <= wb_cnt_q + 16'd1;
               end
            end
            StWriteback: begin
               if (pmem_resp) state_q <= StAllocate;
            end
            StAllocate: begin
               if (pmem_resp) begin
                  fill_buf_q <= pmem_rdata;
                  state_q    <= StFill;
               end
            end
            StFill:  state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
      end
   end

   // All outputs decode from the registered state. The address and data come from the
   // stage-2 fields, and those fields are frozen by stall for as long as a request is open.
   always_comb begin
      pmem_read    = 1'b0;
      pmem_write   = 1'b0;
      pmem_address = '0;
      pmem_wdata   = '0;
      fill_we      = 1'b0;
      fill_way     = 1'b0;
      fill_data    = '0;
      miss_done    = 1'b0;
      stall        = 1'b0;
      case (state_q)
         StIdle: stall = s2_miss;
         StWriteback: begin
            stall        = 1'b1;
            pmem_write   = 1'b1;
            pmem_address = {s2_victim_tag, s2_address[7:5], 5'b0};
            pmem_wdata   = s2_victim_data;
         end
         StAllocate: begin
            stall        = 1'b1;
            pmem_read    = 1'b1;
            pmem_address = {s2_address[31:5], 5'b0};
         end
         StFill: begin
            fill_we   = 1'b1;
            fill_way  = s2_lru;
            fill_data = fill_buf_q;
            miss_done = 1'b1;
         end
         default: stall = 1'b0;
      endcase
   end

   assign miss_count = miss_cnt_q;
   assign wb_count   = wb_cnt_q;

endmodule

// File: tb/tb_pipelined_cache_miss_ctrl.sv
// Directed self-checking bench for pipelined_cache_miss_ctrl.
// The counter ceiling is lowered to 20 so that the saturation scenario stays short.
module tb_pipelined_cache_miss_ctrl;

   localparam logic [15:0] Ceiling = 16'd20;

   logic         clk = 1'b0;
   logic         rst;
   logic         s2_valid, s2_hit, s2_dirty, s2_lru;
   logic [31:0]  s2_address;
   logic [23:0]  s2_victim_tag;
   logic [255:0] s2_victim_data;
   logic         pmem_resp;
   logic [255:0] pmem_rdata;
   logic         pmem_read, pmem_write;
   logic [31:0]  pmem_address;
   logic [255:0] pmem_wdata;
   logic         stall, fill_we, fill_way, miss_done;
   logic [255:0] fill_data;
   logic [15:0]  miss_count, wb_count;

   int n_cmp = 0;
   int n_bad = 0;

   localparam logic [255:0] LineA5 = {32{8'hA5}};
   localparam logic [255:0] LineVd = {8{32'hDEAD_BEEF}};
   localparam logic [255:0] Line3C = {32{8'h3C}};

   pipelined_cache_miss_ctrl #(.CountMax(Ceiling)) dut (
      .clk(clk), .rst(rst),
      .s2_valid(s2_valid), .s2_hit(s2_hit), .s2_dirty(s2_dirty), .s2_lru(s2_lru),
      .s2_address(s2_address), .s2_victim_tag(s2_victim_tag),
      .s2_victim_data(s2_victim_data),
      .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata),
      .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
      .pmem_wdata(pmem_wdata), .stall(stall), .fill_we(fill_we), .fill_way(fill_way),
      .fill_data(fill_data), .miss_done(miss_done),
      .miss_count(miss_count), .wb_count(wb_count)
   );

   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input logic v, input logic h, input logic d, input logic l,
                          input logic [31:0] a);
      s2_valid   = v;
      s2_hit     = h;
      s2_dirty   = d;
      s2_lru     = l;
      s2_address = a;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      set_req(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      s2_victim_tag  = '0;
      s2_victim_data = '0;
      pmem_resp      = 1'b0;
      pmem_rdata     = '0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      n_cmp++;
      if ({pmem_read, pmem_write, stall, fill_we, fill_way, miss_done} !== 6'b0 ||
          pmem_address !== 32'h0 || pmem_wdata !== '0 || fill_data !== '0) begin
         n_bad++;
         $display("FAIL reset_outputs: rd=%b wr=%b st=%b fwe=%b addr=%h required all zero",
                  pmem_read, pmem_write, stall, fill_we, pmem_address);
      end
      n_cmp++;
      if (miss_count !== 16'd0 || wb_count !== 16'd0) begin
         n_bad++;
         $display("FAIL reset_counters: miss=%0d wb=%0d required 0/0", miss_count, wb_count);
      end
   endtask

   task automatic test_hit();
      int bad_cycles = 0;
      do_reset();
      set_req(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_1A40);
      pmem_resp = 1'b1;
      for (int i = 0; i < 10; i++) begin
         #1;
         if ({stall, pmem_read, pmem_write} !== 3'b000) bad_cycles++;
         tick();
      end
      n_cmp++;
      if (bad_cycles !== 0) begin
         n_bad++;
         $display("FAIL hit_no_stall: %0d cycles with stall/request, required 0", bad_cycles);
      end
      n_cmp++;
      if (miss_count !== 16'd0) begin
         n_bad++;
         $display("FAIL hit_miss_count: got %0d required 0", miss_count);
      end
   endtask

   task automatic test_clean_miss();
      do_reset();
      set_req(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_1A40);
      #1;
      n_cmp++;
      if ({stall, pmem_read, pmem_write} !== 3'b100) begin
         n_bad++;
         $display("FAIL clean_idle: st/rd/wr=%b required 100", {stall, pmem_read, pmem_write});
      end
      tick();
      for (int i = 0; i < 3; i++) begin
         if (i == 2) begin
            pmem_resp  = 1'b1;
            pmem_rdata = LineA5;
         end
         #1;
         n_cmp++;
         if ({stall, pmem_read, pmem_write, fill_we} !== 4'b1100 ||
             pmem_address !== 32'h0000_1A40 || fill_data !== '0) begin
            n_bad++;
            $display("FAIL clean_alloc[%0d]: st/rd/wr/fwe=%b addr=%h required 1100 addr 00001a40",
                     i, {stall, pmem_read, pmem_write, fill_we}, pmem_address);
         end
         tick();
      end
      pmem_resp  = 1'b0;
      pmem_rdata = '0;
      #1;
      n_cmp++;
      if ({fill_we, fill_way, miss_done, stall, pmem_read} !== 5'b11100 ||
          fill_data !== LineA5) begin
         n_bad++;
         $display("FAIL clean_fill: fwe/way/done/st/rd=%b data=%h required 11100 A5..A5",
                  {fill_we, fill_way, miss_done, stall, pmem_read}, fill_data[31:0]);
      end
      tick();
      s2_valid = 1'b0;
      #1;
      n_cmp++;
      if ({fill_we, miss_done, stall} !== 3'b000 || fill_data !== '0 ||
          miss_count !== 16'd1 || wb_count !== 16'd0) begin
         n_bad++;
         $display("FAIL clean_after: fwe/done/st=%b miss=%0d wb=%0d required 000 1 0",
                  {fill_we, miss_done, stall}, miss_count, wb_count);
      end
   endtask

   task automatic test_dirty_miss();
      do_reset();
      set_req(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_3460);
      s2_victim_tag  = 24'h00_0012;
      s2_victim_data = LineVd;
      tick();
      for (int i = 0; i < 2; i++) begin
         if (i == 1) pmem_resp = 1'b1;
         #1;
         n_cmp++;
         if ({pmem_write, pmem_read, stall} !== 3'b101 || pmem_address !== 32'h0000_1260 ||
             pmem_wdata !== LineVd) begin
            n_bad++;
            $display("FAIL dirty_wb[%0d]: wr/rd/st=%b addr=%h required 101 addr 00001260",
                     i, {pmem_write, pmem_read, stall}, pmem_address);
         end
         tick();
      end
      pmem_resp = 1'b0;
      #1;
      n_cmp++;
      if ({pmem_read, pmem_write, stall} !== 3'b101 || pmem_address !== 32'h0000_3460 ||
          pmem_wdata !== '0 || wb_count !== 16'd1) begin
         n_bad++;
         $display("FAIL dirty_alloc: rd/wr/st=%b addr=%h wb=%0d required 101 addr 00003460 wb 1",
                  {pmem_read, pmem_write, stall}, pmem_address, wb_count);
      end
      pmem_resp  = 1'b1;
      pmem_rdata = Line3C;
      tick();
      pmem_resp  = 1'b0;
      #1;
      n_cmp++;
      if ({fill_we, fill_way, miss_done} !== 3'b101 || fill_data !== Line3C) begin
         n_bad++;
         $display("FAIL dirty_fill: fwe/way/done=%b data=%h required 101 3C..3C",
                  {fill_we, fill_way, miss_done}, fill_data[31:0]);
      end
      tick();
      s2_valid = 1'b0;
      #1;
      n_cmp++;
      if (miss_count !== 16'd1 || wb_count !== 16'd1) begin
         n_bad++;
         $display("FAIL dirty_counts: miss=%0d wb=%0d required 1/1", miss_count, wb_count);
      end
   endtask

   task automatic test_reset_mid_alloc();
      do_reset();
      set_req(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_5000);
      tick();
      #1;
      n_cmp++;
      if (pmem_read !== 1'b1 || miss_count !== 16'd1) begin
         n_bad++;
         $display("FAIL rst_pre: rd=%b miss=%0d required 1/1", pmem_read, miss_count);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      s2_valid = 1'b0;
      #1;
      n_cmp++;
      if ({pmem_read, pmem_write, stall} !== 3'b000 || pmem_address !== 32'h0 ||
          miss_count !== 16'd0) begin
         n_bad++;
         $display("FAIL rst_abandon: rd/wr/st=%b addr=%h miss=%0d required 000 0 0",
                  {pmem_read, pmem_write, stall}, pmem_address, miss_count);
      end
      pmem_resp  = 1'b1;
      pmem_rdata = LineA5;
      tick();
      tick();
      pmem_resp = 1'b0;
      #1;
      n_cmp++;
      if ({fill_we, miss_done, pmem_read, stall} !== 4'b0000 || fill_data !== '0 ||
          miss_count !== 16'd0) begin
         n_bad++;
         $display("FAIL rst_late_resp: fwe/done/rd/st=%b miss=%0d required 0000 0",
                  {fill_we, miss_done, pmem_read, stall}, miss_count);
      end
   endtask

   // Memory answers in the same cycle as each request. The misses follow each other with
   // no gap between them.
   task automatic test_back_to_back();
      logic [31:0]  addrs [3] = '{32'h0000_1A40, 32'h0000_2B60, 32'h0000_7700};
      logic         dirts [3] = '{1'b0, 1'b0, 1'b1};
      int           want  [3] = '{2, 2, 3};
      do_reset();
      pmem_resp      = 1'b1;
      pmem_rdata     = Line3C;
      s2_victim_tag  = 24'hAB_CDEF;
      s2_victim_data = LineVd;
      for (int m = 0; m < 3; m++) begin
         int  stalls  = 0;
         int  overlap = 0;
         bit  done    = 1'b0;
         set_req(1'b1, 1'b0, dirts[m], 1'b1, addrs[m]);
         for (int c = 0; c < 10 && !done; c++) begin
            #1;
            if (stall) stalls++;
            if (pmem_read && pmem_write) overlap++;
            if (fill_we) begin
               done = 1'b1;
               n_cmp++;
               if (fill_data !== Line3C || fill_way !== 1'b1 || miss_done !== 1'b1) begin
                  n_bad++;
                  $display("FAIL b2b_fill[%0d]: data=%h way=%b done=%b required 3C..3C 1 1",
                           m, fill_data[31:0], fill_way, miss_done);
               end
            end
            tick();
         end
         n_cmp++;
         if (!done || stalls != want[m] || overlap != 0) begin
            n_bad++;
            $display("FAIL b2b_latency[%0d]: done=%b stalls=%0d overlap=%0d required 1 %0d 0",
                     m, done, stalls, overlap, want[m]);
         end
      end
      s2_valid  = 1'b0;
      pmem_resp = 1'b0;
      #1;
      n_cmp++;
      if (miss_count !== 16'd3 || wb_count !== 16'd1) begin
         n_bad++;
         $display("FAIL b2b_counts: miss=%0d wb=%0d required 3/1", miss_count, wb_count);
      end
   endtask

   task automatic test_saturation();
      do_reset();
      pmem_resp = 1'b1;
      set_req(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0100);
      for (int i = 0; i < 19; i++) begin
         tick();
         tick();
         tick();
      end
      s2_valid = 1'b0;
      #1;
      n_cmp++;
      if (miss_count !== 16'd19) begin
         n_bad++;
         $display("FAIL sat_below: miss=%0d required 19", miss_count);
      end
      // Three more clean misses and 22 dirty ones push both counters past the ceiling.
      s2_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         tick();
         tick();
      end
      s2_dirty = 1'b1;
      for (int i = 0; i < 22; i++) begin
         tick();
         tick();
         tick();
         tick();
      end
      s2_valid = 1'b0;
      #1;
      n_cmp++;
      if (miss_count !== Ceiling || wb_count !== Ceiling) begin
         n_bad++;
         $display("FAIL sat_ceiling: miss=%0d wb=%0d required %0d/%0d",
                  miss_count, wb_count, Ceiling, Ceiling);
      end
      pmem_resp = 1'b0;
   endtask

   initial begin
      test_reset();
      test_hit();
      test_clean_miss();
      test_dirty_miss();
      test_reset_mid_alloc();
      test_back_to_back();
      test_saturation();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
